tx_pkt_arbiter: RTL and testbench
=================================

Name: tx_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one TCP tx path (pkt_sender input stream) between NUM_REQ requester streams.
- Each requester stream uses the same format as the pkt_sender input: {size metadata[31:0], tlast, tdata[511:0]}.
- Grant is locked for a whole packet. New grants are throttled by a credit counter of packets in flight, meaning sent but tx status not yet returned.
- Sits between the top-k result generators and pkt_sender.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- PKT_W, 545, beat width: bits [544:513] metadata, bit [512] tlast, bits [511:0] data.
- MAX_OUTSTANDING, 16, maximum packets in flight.
- CNT_W, 5, credit counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- s_pkt_TDATA, in, NUM_REQ*PKT_W: requester beats; requester i occupies slice [i*PKT_W +: PKT_W].
- s_pkt_TVALID, in, NUM_REQ: per-requester valid.
- s_pkt_TREADY, out, NUM_REQ: per-requester ready.
- m_pkt_TDATA, out, PKT_W: arbitrated beat to pkt_sender.
- m_pkt_TVALID, out, 1: output valid.
- m_pkt_TREADY, in, 1: output ready.
- tx_status_fire, in, 1: one-cycle pulse, one per packet status consumed from tx status stream.
- grant, out, NUM_REQ: one-hot current owner; 0 when idle.
- outstanding, out, CNT_W: packets in flight.
- status_underflow, out, 1: sticky error flag.

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: grant=0, state=IDLE, m_pkt_TVALID=0, s_pkt_TREADY=0, outstanding=0, status_underflow=0, rr_ptr=NUM_REQ-1 (so first search starts at requester 0).
- States: IDLE, BUSY.
- IDLE, selection:
  - Condition: any s_pkt_TVALID and outstanding < MAX_OUTSTANDING.
  - Pick the first valid requester searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_REQ wrap.
  - Register the one-hot grant and go to BUSY next cycle.
  - Arbitration latency: 1 cycle. No beat is transferred in IDLE.
- IDLE, no eligible requester: stay in IDLE, grant=0, all ready=0, m_pkt_TVALID=0.
- BUSY, datapath:
  - Combinational passthrough from the granted requester g: m_pkt_TDATA = slice g; m_pkt_TVALID = s_pkt_TVALID[g]; s_pkt_TREADY[g] = m_pkt_TREADY.
  - All other ready bits are 0.
  - No data buffering; zero-latency beat path.
- BUSY, end of packet:
  - Condition: beat accepted (m_pkt_TVALID & m_pkt_TREADY) with tdata bit 512 = 1.
  - Actions: go to IDLE, rr_ptr <= g, grant <= 0.
  - A new grant can therefore be issued at the earliest on the following cycle; one idle bubble per packet is accepted.
- Backpressure and valid drops in BUSY: grant holds; the data beat remains sourced from the owner.
- Credit counter:
  - +1 on the last-beat handshake; -1 on tx_status_fire.
  - Both in the same cycle: unchanged.
  - tx_status_fire with outstanding=0 and no simultaneous last beat: counter stays 0 and status_underflow sets (cleared only by reset).
  - Counter never exceeds MAX_OUTSTANDING, because grants are only issued below it.
- Credit exhaustion: reaching MAX_OUTSTANDING blocks only new grants. A packet already granted always completes.
- Metadata bits pass through unmodified. The arbiter does not inspect size.
- Reset mid-packet: immediate return to reset values. The partial packet is abandoned and upstream FIFOs are reset by the same rst_n.

Optional Feature:
- Macro TX_PKT_ARB_STATS_EN.
- When defined:
  - Adds output pkt_count, width NUM_REQ*32: per-requester count of completed packets (last-beat handshakes).
  - Counters are 32-bit, wrap at 2^32, reset to 0.
  - Adds output stall_cycles, width 32: cycles in IDLE with a valid request blocked by credit exhaustion.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package tx_arb_pkg:
  - Constants: META_W=32, DATA_W=512, TLAST_BIT=512, META_LSB=513.
  - State enum: IDLE, BUSY.
- One sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: one-hot gnt, any.
  - Reused by other arbiters in the kernel.

Test Plan:
- Single requester: req0 sends a 3-beat packet with m_pkt_TREADY=1 -> grant=0001 one cycle after valid; 3 beats out unmodified; outstanding=1; then IDLE.
- Fairness: req0 and req2 continuously valid with 1-beat packets -> grant order 0,2,0,2; no interleaving of beats within a packet.
- Backpressure: m_pkt_TREADY toggled every cycle during a 4-beat packet -> grant stable; exactly 4 handshakes; s_pkt_TREADY mirrors m_pkt_TREADY only for the owner.
- Credit exhaustion: MAX_OUTSTANDING=2, three queued packets, no status -> third packet not granted. One tx_status_fire -> grant issued next cycle, outstanding returns to 2.
- Simultaneous events: last-beat handshake and tx_status_fire in the same cycle at outstanding=1 -> outstanding stays 1. tx_status_fire at outstanding=0 -> status_underflow=1, counter 0.
- Reset mid-packet: rst_n low during beat 2 of 4 -> grant=0, m_pkt_TVALID=0 immediately. After release, next arbitration starts at requester 0.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared constants and state type for the tx packet arbiter.
// Beat layout: [544:513] size metadata, [512] tlast, [511:0] data.
package tx_arb_pkg;

    localparam int META_W    = 32;
    localparam int DATA_W    = 512;
    localparam int TLAST_BIT = 512;
    localparam int META_LSB  = 513;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: grants the first set request after ptr_i,
// wrapping modulo NUM_REQ. Purely combinational; shared by kernel arbiters.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               any_o
);

    logic [PTR_W-1:0] idx;

    // Walk ptr+1 .. ptr+NUM_REQ and keep the first hit.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter in front of pkt_sender.
// Grant is locked per packet; new grants are throttled by a credit counter
// of packets sent but whose tx status has not yet returned.
// Optional statistics (per-requester packet count, credit stall cycles)
// are built when TX_PKT_ARB_STATS_EN is defined.
module tx_pkt_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int PKT_W           = 545,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ*PKT_W-1:0] s_pkt_TDATA,
    input  logic [NUM_REQ-1:0]       s_pkt_TVALID,
    output logic [NUM_REQ-1:0]       s_pkt_TREADY,
    output logic [PKT_W-1:0]         m_pkt_TDATA,
    output logic                     m_pkt_TVALID,
    input  logic                     m_pkt_TREADY,
    input  logic                     tx_status_fire,
    output logic [NUM_REQ-1:0]       grant,
    output logic [CNT_W-1:0]         outstanding,
    output logic                     status_underflow
`ifdef TX_PKT_ARB_STATS_EN
   ,output logic [NUM_REQ*32-1:0]    pkt_count,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                     state_q;
    logic [NUM_REQ-1:0]             grant_q;
    logic [PTR_W-1:0]               gidx_q;
    logic [PTR_W-1:0]               rr_ptr_q;
    logic [CNT_W-1:0]               outstanding_q, outstanding_d;
    logic                           underflow_q, underflow_d;

    logic [NUM_REQ-1:0][PKT_W-1:0]  beats;
    logic [NUM_REQ-1:0]             pick_gnt;
    logic                           pick_any;
    logic [PTR_W-1:0]               pick_idx;
    logic                           busy, credit_ok, can_grant, last_hs;

    assign beats     = s_pkt_TDATA;
    assign busy      = (state_q == BUSY);
    assign credit_ok = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign can_grant = !busy && pick_any && credit_ok;
    assign last_hs   = m_pkt_TVALID && m_pkt_TREADY && m_pkt_TDATA[TLAST_BIT];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (s_pkt_TVALID),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    // One-hot pick to index, used to steer the beat mux.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end

    // Zero-latency beat path from the owner; everything quiet when idle.
    always_comb begin
        m_pkt_TDATA  = '0;
        m_pkt_TVALID = 1'b0;
        s_pkt_TREADY = '0;
        if (busy) begin
            m_pkt_TDATA          = beats[gidx_q];
            m_pkt_TVALID         = s_pkt_TVALID[gidx_q];
            s_pkt_TREADY[gidx_q] = m_pkt_TREADY;
        end
    end

    // Credit next-state: simultaneous +1/-1 cancel; a stray status at zero is flagged.
    always_comb begin
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (last_hs && !tx_status_fire)
            outstanding_d = outstanding_q + CNT_W'(1);
        else if (!last_hs && tx_status_fire) begin
            if (outstanding_q == '0) underflow_d   = 1'b1;
            else                     outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // Arbitration FSM: grant in IDLE, hold through the packet, release on tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: if (can_grant) begin
                    state_q <= BUSY;
                    grant_q <= pick_gnt;
                    gidx_q  <= pick_idx;
                end
                BUSY: if (last_hs) begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    rr_ptr_q <= gidx_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Credit counter and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign grant            = grant_q;
    assign outstanding      = outstanding_q;
    assign status_underflow = underflow_q;

`ifdef TX_PKT_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] pkt_count_q;
    logic [31:0]              stall_q;

    // Completed packets per requester and credit-blocked idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
            stall_q     <= '0;
        end else begin
            if (last_hs)
                pkt_count_q[gidx_q] <= pkt_count_q[gidx_q] + 32'd1;
            if (!busy && (|s_pkt_TVALID) && !credit_ok)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign pkt_count    = pkt_count_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter (NUM_REQ=4, MAX_OUTSTANDING=2).
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_tx_pkt_arbiter;

    localparam int NR = 4;
    localparam int PW = 545;
    localparam int CW = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NR-1:0][PW-1:0] s_data;
    logic [NR-1:0]         s_valid;
    logic [NR-1:0]         s_ready;
    logic [PW-1:0]         m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  fire;
    logic [NR-1:0]         grant;
    logic [CW-1:0]         outstanding;
    logic                  underflow;
`ifdef TX_PKT_ARB_STATS_EN
    logic [NR*32-1:0]      pkt_count;
    logic [31:0]           stall_cycles;
`endif

    int n_total = 0;
    int n_bad   = 0;

    tx_pkt_arbiter #(.NUM_REQ(NR), .PKT_W(PW), .MAX_OUTSTANDING(2), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_pkt_TDATA      (s_data),
        .s_pkt_TVALID     (s_valid),
        .s_pkt_TREADY     (s_ready),
        .m_pkt_TDATA      (m_data),
        .m_pkt_TVALID     (m_valid),
        .m_pkt_TREADY     (m_ready),
        .tx_status_fire   (fire),
        .grant            (grant),
        .outstanding      (outstanding),
        .status_underflow (underflow)
`ifdef TX_PKT_ARB_STATS_EN
       ,.pkt_count        (pkt_count),
        .stall_cycles     (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] meta, input logic last, input logic [511:0] d);
        return {meta, last, d};
    endfunction

    initial begin
        int exp_g [4];
        int b;
        exp_g = '{0, 2, 0, 2};
        rst_n = 1'b0; s_data = '0; s_valid = '0; m_ready = 1'b0; fire = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        smp();
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_outst", outstanding, 0);
        chk("rst_uflow", underflow, 0);
        tick(); rst_n = 1'b1;
        tick();

        // fairness: req0 and req2 always valid, 1-beat packets
        s_data[0] = mk(32'd0, 1'b1, 512'hA0);
        s_data[2] = mk(32'd2, 1'b1, 512'hA2);
        s_valid = 4'b0101; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fire = (k > 0);
            smp();
            chk("fair_idle", grant, 0);
            chk("fair_idle_v", m_valid, 0);
            tick(); fire = 1'b0;
            smp();
            chk("fair_gnt", grant, 4'(1 << exp_g[k]));
            chk("fair_data", m_data, mk(32'(exp_g[k]), 1'b1, 512'hA0 + 512'(exp_g[k])));
            chk("fair_rdy", s_ready, 4'(1 << exp_g[k]));
            tick();
        end
        s_valid = '0;
        smp(); chk("fair_outst", outstanding, 1);
        fire = 1'b1; tick(); fire = 1'b0;
        smp(); chk("fair_drain", outstanding, 0);

        // single requester, 3-beat packet (rr_ptr=2 -> req0)
        tick();
        s_data[0] = mk(32'h1111, 1'b0, 512'hB0); s_valid = 4'b0001;
        smp(); chk("one_arb", grant, 0); chk("one_arb_v", m_valid, 0);
        tick();
        smp(); chk("one_gnt", grant, 4'b0001); chk("one_v", m_valid, 1);
        chk("one_b0", m_data, mk(32'h1111, 1'b0, 512'hB0));
        tick(); s_data[0] = mk(32'h1111, 1'b0, 512'hB1);
        smp(); chk("one_b1", m_data, mk(32'h1111, 1'b0, 512'hB1));
        tick(); s_data[0] = mk(32'h1111, 1'b1, 512'hB2);
        smp(); chk("one_b2", m_data, mk(32'h1111, 1'b1, 512'hB2)); chk("one_outst0", outstanding, 0);
        tick(); s_valid = '0;
        smp(); chk("one_end", grant, 0); chk("one_outst1", outstanding, 1); chk("one_end_v", m_valid, 0);
        fire = 1'b1; tick(); fire = 1'b0;
        smp(); chk("one_drain", outstanding, 0);

        // backpressure: ready toggles during 4-beat packet from req1
        tick();
        s_data[1] = mk(32'h2222, 1'b0, 512'hC0); s_valid = 4'b0010; m_ready = 1'b0;
        smp(); chk("bp_arb", grant, 0);
        tick();
        b = 0;
        for (int c = 0; c < 8; c++) begin
            m_ready = c[0];
            smp();
            chk("bp_gnt", grant, 4'b0010);
            chk("bp_rdy", s_ready, m_ready ? 4'b0010 : 4'b0000);
            chk("bp_data", m_data, mk(32'h2222, (b == 3), 512'hC0 + 512'(b)));
            tick();
            if (m_ready) begin
                b++;
                if (b < 4) s_data[1] = mk(32'h2222, (b == 3), 512'hC0 + 512'(b));
                else       s_valid = '0;
            end
        end
        m_ready = 1'b1;
        smp(); chk("bp_end", grant, 0); chk("bp_outst", outstanding, 1);

        // last beat and status together at outstanding=1 (rr_ptr=1 -> req3)
        tick();
        s_data[3] = mk(32'd3, 1'b1, 512'hD3); s_valid = 4'b1000;
        smp(); chk("sim_arb", grant, 0);
        tick(); fire = 1'b1;
        smp(); chk("sim_gnt", grant, 4'b1000);
        tick(); fire = 1'b0; s_valid = '0;
        smp(); chk("sim_outst", outstanding, 1);
        fire = 1'b1; tick(); fire = 1'b0;
        smp(); chk("sim_outst0", outstanding, 0); chk("sim_uflow0", underflow, 0);
        fire = 1'b1; tick(); fire = 1'b0;
        smp(); chk("uflow_cnt", outstanding, 0); chk("uflow_flag", underflow, 1);

        // credit exhaustion: three queued packets, limit 2
        tick();
        s_data[0] = mk(32'd0, 1'b1, 512'hE0);
        s_data[1] = mk(32'd1, 1'b1, 512'hE1);
        s_data[2] = mk(32'd2, 1'b1, 512'hE2);
        s_valid = 4'b0111;
        smp(); chk("cr_arb0", grant, 0);
        tick();
        smp(); chk("cr_g0", grant, 4'b0001);
        tick(); s_valid = 4'b0110;
        smp(); chk("cr_arb1", grant, 0);
        tick();
        smp(); chk("cr_g1", grant, 4'b0010);
        tick(); s_valid = 4'b0100;
        smp(); chk("cr_full", outstanding, 2); chk("cr_blk0", grant, 0);
        tick();
        smp(); chk("cr_blk1", grant, 0); chk("cr_blk_v", m_valid, 0);
        fire = 1'b1; tick(); fire = 1'b0;
        smp(); chk("cr_blk2", grant, 0); chk("cr_outst1", outstanding, 1);
        tick();
        smp(); chk("cr_g2", grant, 4'b0100); chk("cr_d2", m_data, mk(32'd2, 1'b1, 512'hE2));
        tick(); s_valid = '0;
        smp(); chk("cr_outst2", outstanding, 2); chk("cr_end", grant, 0);

        // drain, then reset in the middle of a 4-beat packet from req1
        fire = 1'b1; tick(); tick(); fire = 1'b0;
        smp(); chk("rm_drain", outstanding, 0);
        tick();
        s_data[1] = mk(32'h5555, 1'b0, 512'hF0); s_valid = 4'b0010;
        smp(); chk("rm_arb", grant, 0);
        tick();
        smp(); chk("rm_gnt", grant, 4'b0010);
        tick(); s_data[1] = mk(32'h5555, 1'b0, 512'hF1);
        smp(); chk("rm_b1", m_data, mk(32'h5555, 1'b0, 512'hF1));
        #1 rst_n = 1'b0;
        #1;
        chk("rm_grant", grant, 0);
        chk("rm_mvalid", m_valid, 0);
        chk("rm_sready", s_ready, 0);
        chk("rm_uflow", underflow, 0);
        s_valid = '0;
        tick(); tick(); rst_n = 1'b1;
        tick();
        // rr_ptr back to 3: search starts at 0 and lands on req2 before req3
        s_data[2] = mk(32'd2, 1'b1, 512'h92);
        s_data[3] = mk(32'd3, 1'b1, 512'h93);
        s_valid = 4'b1100;
        smp(); chk("rm_arb2", grant, 0);
        tick();
        smp(); chk("rm_first", grant, 4'b0100);
        tick(); s_valid = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
